// File: rtl/dup_gen.sv
// Parametrised up/down sequencer counter with wrap, saturate and ping-pong modes and a registered terminal-count pulse.
// Optional event counter output evt_cnt is enabled by defining DUP_EVTCNT_EN.
module dup_gen #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 9,
  parameter int INIT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             tc
`ifdef DUP_EVTCNT_EN
  ,
  output logic [7:0]       evt_cnt
`endif
);

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_Q = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ZERO_Q = '0;
  localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

  logic [WIDTH-1:0] q_r, q_s;
  logic             dir_r, dir_s;
  logic             tc_r, tc_s;
  logic             d_s;
  logic             at_bnd_s;

  function automatic logic [WIDTH-1:0] clamp_ld(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > MAX_Q) begin
      r = MAX_Q;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Effective direction and boundary detection for the current edge.
  always_comb begin
    d_s = up_dn;
    case (mode)
      2'b10:   d_s = dir_r;
      default: d_s = up_dn;
    endcase
    if (d_s) begin
      at_bnd_s = (q_r == MAX_Q);
    end else begin
      at_bnd_s = (q_r == ZERO_Q);
    end
  end

  // Next-state: load beats enable beats hold; tc only asserts on a boundary step.
  always_comb begin
    q_s   = q_r;
    dir_s = dir_r;
    tc_s  = 1'b0;
    if (ld) begin
      q_s   = clamp_ld(ld_val);
      dir_s = up_dn;
    end else if (en) begin
      case (mode)
        2'b00: begin
          dir_s = up_dn;
          tc_s  = at_bnd_s;
          if (up_dn) begin
            q_s = at_bnd_s ? ZERO_Q : (q_r + ONE_Q);
          end else begin
            q_s = at_bnd_s ? MAX_Q : (q_r - ONE_Q);
          end
        end
        2'b01: begin
          dir_s = up_dn;
          tc_s  = at_bnd_s;
          if (at_bnd_s) begin
            q_s = q_r;
          end else if (up_dn) begin
            q_s = q_r + ONE_Q;
          end else begin
            q_s = q_r - ONE_Q;
          end
        end
        2'b10: begin
          // Reverse and step on the same edge so the count never dwells at an end.
          tc_s = at_bnd_s;
          if (at_bnd_s) begin
            dir_s = ~dir_r;
            q_s   = dir_r ? (MAX_Q - ONE_Q) : ONE_Q;
          end else if (dir_r) begin
            q_s = q_r + ONE_Q;
          end else begin
            q_s = q_r - ONE_Q;
          end
        end
        default: begin
          q_s   = q_r;
          dir_s = dir_r;
          tc_s  = 1'b0;
        end
      endcase
    end else begin
      q_s   = q_r;
      dir_s = dir_r;
      tc_s  = 1'b0;
    end
  end

  // Count, direction and terminal-count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r   <= INIT_Q;
      dir_r <= 1'b1;
      tc_r  <= 1'b0;
    end else begin
      q_r   <= q_s;
      dir_r <= dir_s;
      tc_r  <= tc_s;
    end
  end

`ifdef DUP_EVTCNT_EN
  logic [7:0] evt_cnt_r;

  // Saturating count of boundary events, cleared by load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_cnt_r <= 8'd0;
    end else if (ld) begin
      evt_cnt_r <= 8'd0;
    end else if (tc_s && (evt_cnt_r != 8'd255)) begin
      evt_cnt_r <= evt_cnt_r + 8'd1;
    end else begin
      evt_cnt_r <= evt_cnt_r;
    end
  end

  assign evt_cnt = evt_cnt_r;
`endif

  assign q   = q_r;
  assign dir = dir_r;
  assign tc  = tc_r;

endmodule

// File: tb/tb_dup_gen.sv
// Table-driven bench for dup_gen (WIDTH=4, MAX_VAL=9, INIT=0) plus hand sequences for asynchronous reset.
module tb_dup_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       ld = 1'b0;
  logic [3:0] ld_val = 4'd0;
  logic [3:0] q;
  logic       dir;
  logic       tc;
`ifdef DUP_EVTCNT_EN
  logic [7:0] evt_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up_dn;
    logic [1:0] mode;
    logic       ld;
    logic [3:0] ld_val;
    logic [3:0] exp_q;
    logic       exp_dir;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  dup_gen #(.WIDTH(4), .MAX_VAL(9), .INIT(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode),
    .ld(ld), .ld_val(ld_val), .q(q), .dir(dir), .tc(tc)
`ifdef DUP_EVTCNT_EN
    , .evt_cnt(evt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic u, input logic [1:0] m,
                     input logic l, input logic [3:0] lv,
                     input logic [3:0] eq, input logic ed, input logic et);
    vec_t v;
    v.rst = r; v.en = e; v.up_dn = u; v.mode = m; v.ld = l; v.ld_val = lv;
    v.exp_q = eq; v.exp_dir = ed; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic [1:0] m,
                       input logic l, input logic [3:0] lv);
    rst = r; en = e; up_dn = u; mode = m; ld = l; ld_val = lv;
  endtask

  initial begin
    // reset held for 3 cycles, en high must be ignored
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    // wrap up: 1..9, 0 (tc), 1, 2
    for (int i = 1; i <= 9; i++) add(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 4'(i), 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    add(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0);
    // wrap down: 1, 0, 9 (tc)
    add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1);
    // saturate up from load 8
    add(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 4'd8, 4'd8, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1);
    add(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1);
    // ping-pong from load 7, up_dn toggled and ignored
    add(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 4'd7, 4'd7, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 4'd0, 4'd8, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 4'd0, 4'd8, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 4'd0, 4'd7, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 4'd0, 4'd6, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) add(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 4'd0, 4'(i), 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 4'd0, 4'd1, 1'b1, 1'b1);
    // load priority and clamp, then mode 11 hold with en high
    add(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 4'd15, 4'd9, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0);
    // en low holds q and dir
    add(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0);
    // entering ping-pong continues in current dir (down)
    add(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0);
    // saturate down at 0
    add(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].en, vecs[i].up_dn, vecs[i].mode, vecs[i].ld, vecs[i].ld_val);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].exp_q));
      chk($sformatf("vec%0d_dir", i), int'(dir), int'(vecs[i].exp_dir));
      chk($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].exp_tc));
    end

    // async reset mid-count at q=6
    @(negedge clk); drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 4'd5);
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 4'd0);
    @(posedge clk); #1;
    chk("arst_pre_q", int'(q), 6);
    #2 rst = 1'b0;
    #1;
    chk("arst_q", int'(q), 0);
    chk("arst_dir", int'(dir), 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("arst_resume_q", int'(q), 1);

    // async reset clears an in-flight tc
    @(negedge clk); drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 4'd9);
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 4'd0);
    @(posedge clk); #1;
    chk("arst_pre_tc", int'(tc), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_tc", int'(tc), 0);
    chk("arst_tc_q", int'(q), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("arst_tc_resume_q", int'(q), 1);

`ifdef DUP_EVTCNT_EN
    @(negedge clk); drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0);
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 4'd0);
    repeat (30) @(negedge clk);
    chk("evt_cnt_30", int'(evt_cnt), 3);
    drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 4'd2);
    @(negedge clk);
    chk("evt_cnt_ld", int'(evt_cnt), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
